// File: rtl/dsp_pkg.sv
// Shared FSM state encoding and DSP mode constants for the MAC sequencer.
package dsp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_OUTPUT = 3'd4
  } state_e;

  localparam logic [1:0] MODE_HALF    = 2'b00;
  localparam logic [1:0] MODE_MIXED   = 2'b01;
  localparam logic [1:0] MODE_FULL    = 2'b10;
  localparam logic [1:0] MODE_ILLEGAL = 2'b11;

endpackage

// File: rtl/dsp_op_buffer.sv
// Operand-pair buffer: synchronous write, registered read that always presents
// the element at the read pointer, so a read strobe yields the next pair with
// no bubble. clr_i discards the contents and zeroes the read port.
module dsp_op_buffer
  import dsp_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned LEN_BITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_a_i,
  input  logic [WIDTH-1:0] wr_b_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_a_o,
  output logic [WIDTH-1:0] rd_b_o
);

  localparam int unsigned DEPTH  = 1 << LEN_BITS;
  localparam int unsigned WORD_W = 2 * WIDTH;

  logic [WORD_W-1:0]   mem_q [DEPTH];
  logic [WORD_W-1:0]   rd_data_q;
  logic [WORD_W-1:0]   wr_word;
  logic [LEN_BITS-1:0] wr_ptr_q;
  logic [LEN_BITS-1:0] rd_ptr_q;
  logic [LEN_BITS-1:0] rd_nxt;

  assign wr_word = {wr_a_i, wr_b_i};
  assign rd_nxt  = LEN_BITS'(rd_ptr_q + 1'b1);
  assign rd_a_o  = rd_data_q[WORD_W-1:WIDTH];
  assign rd_b_o  = rd_data_q[WIDTH-1:0];

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_ptr_q] <= wr_word;
    end
  end

  // Pointers and pre-fetched read register, bypassing a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
    end else begin
      if (wr_en_i) begin
        wr_ptr_q <= LEN_BITS'(wr_ptr_q + 1'b1);
      end
      if (rd_en_i) begin
        rd_ptr_q  <= rd_nxt;
        rd_data_q <= (wr_en_i && (wr_ptr_q == rd_nxt)) ? wr_word : mem_q[rd_nxt];
      end else if (wr_en_i && (wr_ptr_q == rd_ptr_q)) begin
        rd_data_q <= wr_word;
      end
    end
  end

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Sequences one MAC job at a time: latch a command, buffer its operand pairs,
// stream them back-to-back into the DSP, wait out the DSP latency, and hand
// the captured result to the consumer.
module dsp_mac_sequencer
  import dsp_pkg::*;
#(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned SHIFT_BITS    = 2,
  parameter int unsigned PIPELINE_BITS = 3,
  parameter int unsigned LEN_BITS      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [LEN_BITS-1:0]      cmd_len,
  input  logic [1:0]               cmd_mode,
  input  logic [SHIFT_BITS-1:0]    cmd_shift_amount,
  input  logic                     cmd_shift_dir,
  input  logic [PIPELINE_BITS-1:0] cmd_pipe_stages,
  input  logic [2*WIDTH-1:0]       cmd_cc,
  input  logic                     op_valid,
  output logic                     op_ready,
  input  logic [WIDTH-1:0]         op_a,
  input  logic [WIDTH-1:0]         op_b,
  output logic                     dsp_start,
  output logic                     dsp_mac,
  output logic                     dsp_shift_dir,
  output logic [1:0]               dsp_mode,
  output logic [WIDTH-1:0]         dsp_aa,
  output logic [WIDTH-1:0]         dsp_bb,
  output logic [2*WIDTH-1:0]       dsp_cc,
  output logic [SHIFT_BITS-1:0]    dsp_shift_amount,
  output logic [PIPELINE_BITS-1:0] dsp_pipe_stages,
  input  logic [2*WIDTH-1:0]       dsp_out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [2*WIDTH-1:0]       res_data,
  output logic                     res_err
);

  localparam int unsigned ACC_W = 2 * WIDTH;
  localparam logic [PIPELINE_BITS-1:0] PIPE_MAX = PIPELINE_BITS'(PIPELINE_BITS);

  state_e                   state_q;
  logic                     cmd_ready_q;
  logic                     op_ready_q;
  logic                     start_q;
  logic [LEN_BITS-1:0]      len_q;
  logic [LEN_BITS-1:0]      cnt_q;
  logic [1:0]               mode_q;
  logic [SHIFT_BITS-1:0]    shamt_q;
  logic                     sdir_q;
  logic [PIPELINE_BITS-1:0] pipe_q;
  logic [PIPELINE_BITS-1:0] drain_q;
  logic [ACC_W-1:0]         cc_q;
  logic                     res_valid_q;
  logic [ACC_W-1:0]         res_data_q;
  logic                     res_err_q;

  logic last_cnt;
  logic wr_en;
  logic rd_en;
  logic buf_clr;

  assign last_cnt = (cnt_q == len_q);
  assign wr_en    = op_ready_q & op_valid;
  assign rd_en    = (state_q == ST_ISSUE) & ~last_cnt;
  // Drop buffer contents once the last pair is issued or an error job retires.
  assign buf_clr  = ((state_q == ST_ISSUE) & last_cnt) | ((state_q == ST_OUTPUT) & res_ready);

  assign cmd_ready        = cmd_ready_q;
  assign op_ready         = op_ready_q;
  assign dsp_start        = start_q;
  assign dsp_mac          = start_q;
  assign dsp_mode         = mode_q;
  assign dsp_cc           = cc_q;
  assign dsp_shift_amount = shamt_q;
  assign dsp_shift_dir    = sdir_q;
  assign dsp_pipe_stages  = pipe_q;
  assign res_valid        = res_valid_q;
  assign res_data         = res_data_q;
  assign res_err          = res_err_q;

  dsp_op_buffer #(
    .WIDTH    (WIDTH),
    .LEN_BITS (LEN_BITS)
  ) u_op_buffer (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (buf_clr),
    .wr_en_i (wr_en),
    .wr_a_i  (op_a),
    .wr_b_i  (op_b),
    .rd_en_i (rd_en),
    .rd_a_o  (dsp_aa),
    .rd_b_o  (dsp_bb)
  );

  // Job FSM with all control and result outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      op_ready_q  <= 1'b0;
      start_q     <= 1'b0;
      len_q       <= '0;
      cnt_q       <= '0;
      mode_q      <= '0;
      shamt_q     <= '0;
      sdir_q      <= 1'b0;
      pipe_q      <= '0;
      drain_q     <= '0;
      cc_q        <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            len_q       <= cmd_len;
            mode_q      <= cmd_mode;
            shamt_q     <= cmd_shift_amount;
            sdir_q      <= cmd_shift_dir;
            cc_q        <= cmd_cc;
            pipe_q      <= (cmd_pipe_stages > PIPE_MAX) ? PIPE_MAX : cmd_pipe_stages;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b0;
            op_ready_q  <= 1'b1;
            state_q     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (wr_en) begin
            if (last_cnt) begin
              op_ready_q <= 1'b0;
              cnt_q      <= '0;
              if (mode_q == MODE_ILLEGAL) begin
                res_valid_q <= 1'b1;
                res_err_q   <= 1'b1;
                res_data_q  <= '0;
                state_q     <= ST_OUTPUT;
              end else begin
                start_q <= 1'b1;
                state_q <= ST_ISSUE;
              end
            end else begin
              cnt_q <= LEN_BITS'(cnt_q + 1'b1);
            end
          end
        end
        ST_ISSUE: begin
          if (last_cnt) begin
            start_q <= 1'b0;
            cnt_q   <= '0;
            if (pipe_q == '0) begin
              res_data_q  <= dsp_out;
              res_valid_q <= 1'b1;
              state_q     <= ST_OUTPUT;
            end else begin
              drain_q <= PIPELINE_BITS'(pipe_q - 1'b1);
              state_q <= ST_DRAIN;
            end
          end else begin
            cnt_q <= LEN_BITS'(cnt_q + 1'b1);
          end
        end
        ST_DRAIN: begin
          if (drain_q == '0) begin
            res_data_q  <= dsp_out;
            res_valid_q <= 1'b1;
            state_q     <= ST_OUTPUT;
          end else begin
            drain_q <= PIPELINE_BITS'(drain_q - 1'b1);
          end
        end
        ST_OUTPUT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            res_err_q   <= 1'b0;
            res_data_q  <= '0;
            cmd_ready_q <= 1'b1;
            mode_q      <= '0;
            shamt_q     <= '0;
            sdir_q      <= 1'b0;
            pipe_q      <= '0;
            cc_q        <= '0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer with a behavioural DSP model
// (accumulate with per-element shift, selectable output latency).
module tb_dsp_mac_sequencer;

  localparam int unsigned W  = 16;
  localparam int unsigned SB = 2;
  localparam int unsigned PB = 3;
  localparam int unsigned LB = 4;
  localparam logic [31:0] NEG2 = 32'hFFFF_FFFE;

  logic            clk = 1'b0;
  logic            rst;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [LB-1:0]   cmd_len;
  logic [1:0]      cmd_mode;
  logic [SB-1:0]   cmd_shift_amount;
  logic            cmd_shift_dir;
  logic [PB-1:0]   cmd_pipe_stages;
  logic [2*W-1:0]  cmd_cc;
  logic            op_valid;
  logic            op_ready;
  logic [W-1:0]    op_a;
  logic [W-1:0]    op_b;
  logic            dsp_start;
  logic            dsp_mac;
  logic            dsp_shift_dir;
  logic [1:0]      dsp_mode;
  logic [W-1:0]    dsp_aa;
  logic [W-1:0]    dsp_bb;
  logic [2*W-1:0]  dsp_cc;
  logic [SB-1:0]   dsp_shift_amount;
  logic [PB-1:0]   dsp_pipe_stages;
  logic [2*W-1:0]  dsp_out;
  logic            res_valid;
  logic            res_ready;
  logic [2*W-1:0]  res_data;
  logic            res_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dsp_mac_sequencer #(
    .WIDTH         (W),
    .SHIFT_BITS    (SB),
    .PIPELINE_BITS (PB),
    .LEN_BITS      (LB)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_len          (cmd_len),
    .cmd_mode         (cmd_mode),
    .cmd_shift_amount (cmd_shift_amount),
    .cmd_shift_dir    (cmd_shift_dir),
    .cmd_pipe_stages  (cmd_pipe_stages),
    .cmd_cc           (cmd_cc),
    .op_valid         (op_valid),
    .op_ready         (op_ready),
    .op_a             (op_a),
    .op_b             (op_b),
    .dsp_start        (dsp_start),
    .dsp_mac          (dsp_mac),
    .dsp_shift_dir    (dsp_shift_dir),
    .dsp_mode         (dsp_mode),
    .dsp_aa           (dsp_aa),
    .dsp_bb           (dsp_bb),
    .dsp_cc           (dsp_cc),
    .dsp_shift_amount (dsp_shift_amount),
    .dsp_pipe_stages  (dsp_pipe_stages),
    .dsp_out          (dsp_out),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_data         (res_data),
    .res_err          (res_err)
  );

  // DSP model: first start of a burst adds to cc, later ones to the shifted sum.
  logic signed [2*W-1:0] acc_q, acc_c, base_c, sh_c;
  logic        [2*W-1:0] pipe_q [8];
  logic                  prev_start_q;

  always_comb begin
    base_c = prev_start_q ? acc_q : $signed(dsp_cc);
    sh_c   = dsp_shift_dir ? (base_c >>> dsp_shift_amount) : (base_c <<< dsp_shift_amount);
    acc_c  = '0;
    if (dsp_start) acc_c = sh_c + $signed(dsp_aa) * $signed(dsp_bb);
  end

  always_ff @(posedge clk) begin
    acc_q        <= acc_c;
    prev_start_q <= rst ? 1'b0 : dsp_start;
    pipe_q[0]    <= acc_c;
    for (int i = 1; i < 8; i++) pipe_q[i] <= pipe_q[i-1];
  end

  assign dsp_out = (dsp_pipe_stages == '0) ? acc_c : pipe_q[3'(dsp_pipe_stages - 3'd1)];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [LB-1:0] len, input logic [1:0] mode,
                          input logic [SB-1:0] sh, input logic dir,
                          input logic [PB-1:0] pipe, input logic [31:0] cc);
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_len = len; cmd_mode = mode; cmd_shift_amount = sh; cmd_shift_dir = dir;
    cmd_pipe_stages = pipe; cmd_cc = cc; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
  endtask

  task automatic send_op(input logic [W-1:0] a, input logic [W-1:0] b);
    chk("op_ready_load", 32'(op_ready), 32'd1);
    op_a = a; op_b = b; op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
  endtask

  // Observe the issue burst until res_valid, within a fixed cycle budget.
  task automatic run_issue(output int starts, output int macs, output int gaps,
                           output int lat, output int done);
    int first, last;
    starts = 0; macs = 0; first = -1; last = -1; done = 0; lat = -1;
    for (int i = 0; i < 64; i++) begin
      if (dsp_start) begin
        if (first < 0) first = i;
        last = i;
        starts++;
      end
      if (dsp_mac) macs++;
      if (res_valid) begin
        done = 1;
        lat  = (last >= 0) ? (i - last) : 0;
        break;
      end
      tick();
    end
    gaps = (starts > 0) ? (last - first + 1 - starts) : 0;
  endtask

  task automatic retire();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("res_valid_after_hs", 32'(res_valid), 32'd0);
    chk("cmd_ready_after_hs", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int st, mc, gp, lt, dn;
    rst = 1'b1; cmd_valid = 1'b0; cmd_len = '0; cmd_mode = '0; cmd_shift_amount = '0;
    cmd_shift_dir = 1'b0; cmd_pipe_stages = '0; cmd_cc = '0; op_valid = 1'b0;
    op_a = '0; op_b = '0; res_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_op_ready", 32'(op_ready), 32'd0);
    chk("rst_dsp_start", 32'(dsp_start), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_dsp_cc", dsp_cc, 32'd0);

    // Single element, full mode, P=0: 3*-4+10 = -2, result one cycle after start.
    send_cmd(4'd0, 2'b10, 2'd0, 1'b0, 3'd0, 32'd10);
    chk("j1_mode", 32'(dsp_mode), 32'd2);
    chk("j1_cc", dsp_cc, 32'd10);
    send_op(16'd3, 16'hFFFC);
    run_issue(st, mc, gp, lt, dn);
    chk("j1_done", 32'(dn), 32'd1);
    chk("j1_starts", 32'(st), 32'd1);
    chk("j1_macs", 32'(mc), 32'd1);
    chk("j1_latency", 32'(lt), 32'd1);
    chk("j1_data", res_data, NEG2);
    chk("j1_err", 32'(res_err), 32'd0);
    retire();
    chk("j1_idle_cc", dsp_cc, 32'd0);

    // Three elements, half mode: 4+10+18 = 32.
    send_cmd(4'd2, 2'b00, 2'd0, 1'b0, 3'd0, 32'd0);
    send_op(16'd1, 16'd4); send_op(16'd2, 16'd5); send_op(16'd3, 16'd6);
    run_issue(st, mc, gp, lt, dn);
    chk("j2_done", 32'(dn), 32'd1);
    chk("j2_starts", 32'(st), 32'd3);
    chk("j2_gaps", 32'(gp), 32'd0);
    chk("j2_data", res_data, 32'd32);
    retire();

    // Same job with left shift 1 per element: ((4<<1)+10)<<1 + 18 = 54.
    send_cmd(4'd2, 2'b00, 2'd1, 1'b0, 3'd0, 32'd0);
    chk("j3_shamt", 32'(dsp_shift_amount), 32'd1);
    send_op(16'd1, 16'd4); send_op(16'd2, 16'd5); send_op(16'd3, 16'd6);
    run_issue(st, mc, gp, lt, dn);
    chk("j3_done", 32'(dn), 32'd1);
    chk("j3_data", res_data, 32'd54);
    retire();

    // P=3: capture at t+3, res_valid at t+4, result held under backpressure.
    send_cmd(4'd0, 2'b10, 2'd0, 1'b0, 3'd3, 32'd10);
    chk("j4_pipe", 32'(dsp_pipe_stages), 32'd3);
    send_op(16'd3, 16'hFFFC);
    run_issue(st, mc, gp, lt, dn);
    chk("j4_done", 32'(dn), 32'd1);
    chk("j4_latency", 32'(lt), 32'd4);
    chk("j4_data", res_data, NEG2);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("j4_hold_valid", 32'(res_valid), 32'd1);
      chk("j4_hold_data", res_data, NEG2);
      chk("j4_hold_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    retire();

    // Pipe stages above the maximum are clamped to 3.
    send_cmd(4'd0, 2'b10, 2'd0, 1'b0, 3'd7, 32'd10);
    chk("j5_pipe_clamp", 32'(dsp_pipe_stages), 32'd3);
    send_op(16'd3, 16'hFFFC);
    run_issue(st, mc, gp, lt, dn);
    chk("j5_latency", 32'(lt), 32'd4);
    chk("j5_data", res_data, NEG2);
    retire();

    // Right shift, mixed mode: 8*2 = 16, then (16>>>1) + 1*2 = 10.
    send_cmd(4'd1, 2'b01, 2'd1, 1'b1, 3'd0, 32'd0);
    chk("j6_dir", 32'(dsp_shift_dir), 32'd1);
    send_op(16'd8, 16'd2); send_op(16'd1, 16'd2);
    run_issue(st, mc, gp, lt, dn);
    chk("j6_data", res_data, 32'd10);
    retire();

    // Illegal mode: operands consumed, no start, error result.
    send_cmd(4'd1, 2'b11, 2'd0, 1'b0, 3'd0, 32'd5);
    send_op(16'd7, 16'd7); send_op(16'd9, 16'd9);
    chk("j7_op_ready_done", 32'(op_ready), 32'd0);
    run_issue(st, mc, gp, lt, dn);
    chk("j7_done", 32'(dn), 32'd1);
    chk("j7_starts", 32'(st), 32'd0);
    chk("j7_err", 32'(res_err), 32'd1);
    chk("j7_data", res_data, 32'd0);
    retire();
    chk("j7_err_cleared", 32'(res_err), 32'd0);

    // Reset during the second issue cycle of a four-element job.
    send_cmd(4'd3, 2'b10, 2'd0, 1'b0, 3'd0, 32'd0);
    send_op(16'd1, 16'd1); send_op(16'd2, 16'd2); send_op(16'd3, 16'd3); send_op(16'd4, 16'd4);
    chk("j8_issue1", 32'(dsp_start), 32'd1);
    tick();
    chk("j8_issue2", 32'(dsp_start), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("j8_start_low", 32'(dsp_start), 32'd0);
    chk("j8_mac_low", 32'(dsp_mac), 32'd0);
    chk("j8_aa_zero", 32'(dsp_aa), 32'd0);
    chk("j8_mode_zero", 32'(dsp_mode), 32'd0);
    chk("j8_cmd_ready", 32'(cmd_ready), 32'd1);
    op_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("j8_no_result", 32'(res_valid), 32'd0);
      chk("j8_op_ignored", 32'(op_ready), 32'd0);
    end
    op_valid = 1'b0;

    // A fresh job after the abandoned one.
    send_cmd(4'd0, 2'b10, 2'd0, 1'b0, 3'd0, 32'd10);
    send_op(16'd3, 16'hFFFC);
    run_issue(st, mc, gp, lt, dn);
    chk("j9_done", 32'(dn), 32'd1);
    chk("j9_starts", 32'(st), 32'd1);
    chk("j9_data", res_data, NEG2);
    retire();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
